// File: rtl/pwm_peripheral.sv
// PWM peripheral: a free-running prescaled 8-bit counter produces one shared PWM
// level; each of 16 channels is forced off, held on, or follows that level.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 32'd1);

  logic [15:0] psc_q, psc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] out_q, out_d;
  logic        ps_q, ps_d;
  logic        tick_s;
  logic        level_s;
  logic [15:0] en_out_s;
  logic [15:0] en_pwm_s;

  assign en_out_s     = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out          = out_q;
  assign period_start = ps_q;

  // Counter advance, period-boundary duty reload and per-channel output decode.
  always_comb begin
    psc_d   = psc_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    ps_d    = 1'b0;
    out_d   = 16'h0000;
    level_s = 1'b0;
    tick_s  = (psc_q == PSC_LAST);

    if (tick_s) begin
      psc_d = 16'h0000;
      cnt_d = cnt_q + 8'd1;
      // The duty value is sampled only at the wrap so a period is never split.
      if (cnt_q == 8'hFF) begin
        duty_d = pwm_duty_cycle;
        ps_d   = 1'b1;
      end else begin
        duty_d = duty_q;
        ps_d   = 1'b0;
      end
    end else begin
      psc_d = psc_q + 16'd1;
      cnt_d = cnt_q;
    end

    // 0xFF is treated as fully on so there is no one-count low gap at the wrap.
    if (duty_q == 8'hFF) begin
      level_s = 1'b1;
    end else begin
      level_s = (cnt_q < duty_q);
    end

    for (int i = 0; i < 16; i++) begin
      if (!en_out_s[i]) begin
        out_d[i] = 1'b0;
      end else if (!en_pwm_s[i]) begin
        out_d[i] = 1'b1;
      end else begin
        out_d[i] = level_s;
      end
    end
  end

  // State registers; reset returns everything to the start of a fresh period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q  <= 16'h0000;
      cnt_q  <= 8'h00;
      duty_q <= 8'h00;
      out_q  <= 16'h0000;
      ps_q   <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      out_q  <= out_d;
      ps_q   <= ps_d;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral with PRESCALE=13
// (period 3328 clk); expected values are hand-computed high-cycle counts.
module tb_pwm_peripheral;

  localparam int PER = 256 * 13;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int checks;
  int errors;

  pwm_peripheral #(.PRESCALE(13)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
  endtask

  // Steps until period_start is seen; edges = -1 if the budget runs out.
  task automatic wait_ps(input int budget, output int edges, output int highs);
    int i;
    edges = -1;
    highs = 0;
    i = 0;
    while (edges < 0 && i < budget) begin
      step(1);
      i = i + 1;
      if (out[0]) highs = highs + 1;
      if (period_start) edges = i;
    end
  endtask

  task automatic measure(input int n, output int highs, output int pulses, output logic last_ps);
    highs   = 0;
    pulses  = 0;
    last_ps = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (out[0]) highs = highs + 1;
      if (period_start) pulses = pulses + 1;
      last_ps = period_start;
    end
  endtask

  // Measure one aligned period and check its high count and single pulse at the end.
  task automatic check_period(input string tag, input int exp_high);
    int   h;
    int   p;
    logic l;
    measure(PER, h, p, l);
    check({tag, "_high"}, 32'(h), 32'(exp_high));
    check({tag, "_pulses"}, 32'(p), 32'd1);
    check({tag, "_ps_last"}, 32'(l), 32'd1);
  endtask

  initial begin
    int   edges;
    int   highs;
    int   h1;
    int   h2;
    int   p1;
    int   p2;
    logic l;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_en(16'h0001, 16'h0001);
    pwm_duty_cycle = 8'h80;

    #23;
    check("rst_out", 32'(out), 32'h0);
    check("rst_ps", 32'(period_start), 32'h0);

    // First period after reset: shadow duty is 0, so PWM channel stays low.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ps(PER + 100, edges, highs);
    check("first_ps_edges", 32'(edges), 32'(PER));
    check("first_period_high", 32'(highs), 32'd0);

    step(1);
    check("ps_one_cycle", 32'(period_start), 32'd0);
    // Duty written now is held off until the next period.
    pwm_duty_cycle = 8'hFF;
    measure(PER - 1, h1, p1, l);
    check("duty50_high", 32'(h1 + 1), 32'd1664);
    check("duty50_pulses", 32'(p1), 32'd1);
    check("duty50_ps_last", 32'(l), 32'd1);

    check_period("duty_ff_a", PER);
    pwm_duty_cycle = 8'h00;
    check_period("duty_ff_b", PER);
    pwm_duty_cycle = 8'h40;
    check_period("duty_00", 0);

    // Duty change at pwm_cnt == 0x10 must not affect the running period.
    measure(16 * 13, h1, p1, l);
    pwm_duty_cycle = 8'hC0;
    measure(PER - 16 * 13, h2, p2, l);
    check("dutychg_cur_high", 32'(h1 + h2), 32'(64 * 13));
    check("dutychg_cur_pulses", 32'(p1 + p2), 32'd1);
    check("dutychg_cur_ps_last", 32'(l), 32'd1);
    check_period("dutychg_next", 192 * 13);

    // Static on mode.
    set_en(16'h00FF, 16'h0000);
    step(1);
    check("static_out", 32'(out), 32'h00FF);
    step(100);
    check("static_hold", 32'(out), 32'h00FF);

    // Enable dominance with a fully-on duty.
    set_en(16'h0000, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    wait_ps(PER + 100, edges, highs);
    check("dom_ps_found", 32'(edges > 0), 32'd1);
    check("dom_out_zero", 32'(out), 32'h0);
    set_en(16'hFFFF, 16'hFFFF);
    step(1);
    check("dom_out_all", 32'(out), 32'hFFFF);

    // Asynchronous reset mid-period at pwm_cnt == 0x7F.
    set_en(16'h0001, 16'h0001);
    wait_ps(PER + 100, edges, highs);
    step(127 * 13);
    check("prerst_out0", 32'(out[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_ps", 32'(period_start), 32'h0);
    step(2);
    rst_n = 1'b1;
    wait_ps(PER + 100, edges, highs);
    check("rerst_ps_edges", 32'(edges), 32'(PER));
    check("rerst_period_high", 32'(highs), 32'd0);
    check_period("rerst_duty_ff", PER);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
